// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, drives sync-read imem, holds the IF/ID register.
// Optional IF_BUBBLE_CNT_EN adds a saturating count of bubbles loaded.
module instruction_fetch #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned INST_W = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk_n,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] if_curr_inst,
  output logic [ADDR_W-1:0] if_next_addr,
  output logic              if_valid,
  output logic [15:0]       if_bubble_cnt
);

  typedef enum logic {
    S_RESET,
    S_RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic              load_bubble;

  assign pc_inc      = pc_q + 1'b1;
  assign load_bubble = (state == S_RESET) || branch_taken;

  always_comb begin
    pc_next = pc_inc;
    priority case (1'b1)
      branch_taken:       pc_next = branch_addr;
      (state == S_RESET): pc_next = RESET_ADDR;
      stall:              pc_next = pc_q;
      default:            pc_next = pc_inc;
    endcase
  end

  assign imem_addr = pc_next;

  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
      pc_q  <= RESET_ADDR;
    end else begin
      state <= S_RUN;
      pc_q  <= pc_next;
    end
  end

  // Squash wins over stall; stall freezes the whole register.
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      if_curr_inst <= NOP_INST;
      if_next_addr <= '0;
      if_valid     <= 1'b0;
    end else if (load_bubble) begin
      if_curr_inst <= NOP_INST;
      if_next_addr <= '0;
      if_valid     <= 1'b0;
    end else if (!stall) begin
      if_curr_inst <= imem_rdata;
      if_next_addr <= pc_inc;
      if_valid     <= 1'b1;
    end
  end

`ifdef IF_BUBBLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_bubble && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign if_bubble_cnt = cnt_q;
`else
  assign if_bubble_cnt = 16'h0000;
`endif

endmodule
